// File: rtl/i2c_seq_pkg.sv
// Shared types and helpers for the I2C register-transaction sequencer.
// Holds the FSM states, the byte-controller command bundle and the address-byte builder.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_W,
    REG_HI,
    REG_LO,
    DEV_R,
    WDATA,
    RDATA,
    STOP,
    DONE
  } state_e;

  localparam logic I2C_WR_BIT = 1'b0;
  localparam logic I2C_RD_BIT = 1'b1;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } bc_cmd_t;

  localparam bc_cmd_t BC_CMD_NONE = '0;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// Saturating wait counter for one outstanding byte-controller command.
// hit_o fires in the cycle whose edge brings the count up to LIMIT; LIMIT=0 disables it.
module i2c_seq_timeout #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CW'(LIMIT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  if (LIMIT == 0) begin : g_off
    assign hit_o = 1'b0;
  end else begin : g_on
    assign hit_o = en_i && (cnt_q == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/i2c_master_reg_seq.sv
// Expands single-register read/write requests into byte-controller command sequences
// and returns one response (read data or NACK / arbitration-lost / timeout) per request.
module i2c_master_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int          ADDR_BYTES = 1,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [6:0]  req_dev,
  input  logic [15:0] req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_rnw,
  output logic        rsp_nack,
  output logic        rsp_al,
  output logic        rsp_tmo,
  output logic        busy,
  output logic        bc_start,
  output logic        bc_stop,
  output logic        bc_read,
  output logic        bc_write,
  output logic        bc_ack_in,
  output logic [7:0]  bc_din,
  input  logic        bc_cmd_ack,
  input  logic        bc_ack_out,
  input  logic [7:0]  bc_dout,
  input  logic        bc_al,
  output logic        bc_rst
);

  if ((ADDR_BYTES != 1) && (ADDR_BYTES != 2)) begin : g_bad_addr_bytes
    $error("i2c_master_reg_seq: ADDR_BYTES must be 1 or 2");
  end

  state_e      state_q, state_d;
  bc_cmd_t     cmd_q, cmd_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [15:0] reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic        al_q, al_d;
  logic        tmo_q, tmo_d;
  logic        bc_rst_q, bc_rst_d;
  logic        in_cmd;
  logic        tmo_hit;

  assign in_cmd = (state_q != IDLE) && (state_q != DONE);

  // The count restarts whenever a fresh command is loaded (acceptance or any ack).
  i2c_seq_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i ((state_q == IDLE) || bc_cmd_ack),
    .en_i  (in_cmd),
    .hit_o (tmo_hit)
  );

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    state_d  = state_q;
    rnw_d    = rnw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    nack_d   = nack_q;
    al_d     = al_q;
    tmo_d    = tmo_q;
    bc_rst_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = DEV_W;
          rnw_d   = req_rnw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          rdata_d = '0;
          nack_d  = 1'b0;
          al_d    = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        // Priority: arbitration loss, then ack, then timeout.
        if (bc_al) begin
          state_d = DONE;
          al_d    = 1'b1;
        end else if (bc_cmd_ack) begin
          case (state_q)
            DEV_W: begin
              if (bc_ack_out) begin
                state_d = STOP;
                nack_d  = 1'b1;
              end else begin
                state_d = (ADDR_BYTES == 2) ? REG_HI : REG_LO;
              end
            end
            REG_HI: begin
              state_d = bc_ack_out ? STOP : REG_LO;
              nack_d  = bc_ack_out;
            end
            REG_LO: begin
              if (bc_ack_out) begin
                state_d = STOP;
                nack_d  = 1'b1;
              end else begin
                state_d = rnw_q ? DEV_R : WDATA;
              end
            end
            DEV_R: begin
              state_d = bc_ack_out ? STOP : RDATA;
              nack_d  = bc_ack_out;
            end
            WDATA: begin
              // Stop already went out with the data byte, so a NACK ends here.
              state_d = DONE;
              nack_d  = bc_ack_out;
            end
            RDATA: begin
              state_d = DONE;
              rdata_d = bc_dout;
            end
            default: state_d = DONE;
          endcase
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_d    = 1'b1;
          bc_rst_d = 1'b1;
        end
      end
    endcase
  end

  // Command bits follow the next state, so they change on the very edge of the ack.
  always_comb begin
    cmd_d = BC_CMD_NONE;
    case (state_d)
      DEV_W: begin
        cmd_d.start = 1'b1;
        cmd_d.write = 1'b1;
        cmd_d.din   = addr_byte(dev_d, I2C_WR_BIT);
      end
      REG_HI: begin
        cmd_d.write = 1'b1;
        cmd_d.din   = reg_d[15:8];
      end
      REG_LO: begin
        cmd_d.write = 1'b1;
        cmd_d.din   = reg_d[7:0];
      end
      DEV_R: begin
        cmd_d.start = 1'b1;
        cmd_d.write = 1'b1;
        cmd_d.din   = addr_byte(dev_d, I2C_RD_BIT);
      end
      WDATA: begin
        cmd_d.write = 1'b1;
        cmd_d.stop  = 1'b1;
        cmd_d.din   = wdata_d;
      end
      RDATA: begin
        cmd_d.read   = 1'b1;
        cmd_d.stop   = 1'b1;
        cmd_d.ack_in = 1'b1;
      end
      STOP: cmd_d.stop = 1'b1;
      default: cmd_d = BC_CMD_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= BC_CMD_NONE;
      rnw_q    <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      nack_q   <= 1'b0;
      al_q     <= 1'b0;
      tmo_q    <= 1'b0;
      bc_rst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rnw_q    <= rnw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      nack_q   <= nack_d;
      al_q     <= al_d;
      tmo_q    <= tmo_d;
      bc_rst_q <= bc_rst_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_rnw   = rnw_q;
  assign rsp_nack  = nack_q;
  assign rsp_al    = al_q;
  assign rsp_tmo   = tmo_q;
  assign bc_start  = cmd_q.start;
  assign bc_stop   = cmd_q.stop;
  assign bc_read   = cmd_q.read;
  assign bc_write  = cmd_q.write;
  assign bc_ack_in = cmd_q.ack_in;
  assign bc_din    = cmd_q.din;
  assign bc_rst    = bc_rst_q;

endmodule

// File: tb/tb_i2c_master_reg_seq.sv
// Bench for i2c_master_reg_seq: two instances (1-byte address with a 20-cycle timeout,
// 2-byte address with timeout disabled) driven by a byte-controller model and scoreboards.
`timescale 1ns/1ps
module tb_i2c_master_reg_seq;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       rd;
    logic       wr;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  typedef struct packed {
    logic       rnw;
    logic       nack;
    logic       al;
    logic       tmo;
    logic [7:0] rdata;
  } rsp_t;

  localparam int LAT = 2;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_rnw;
  logic [1:0][6:0]  req_dev;
  logic [1:0][15:0] req_reg;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       rsp_valid, rsp_rnw, rsp_nack, rsp_al, rsp_tmo, busy;
  logic [1:0][7:0]  rsp_rdata;
  logic [1:0]       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [1:0][7:0]  bc_din;
  logic [1:0]       bc_cmd_ack, bc_ack_out, bc_al, bc_rst;
  logic [1:0][7:0]  bc_dout;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    i2c_master_reg_seq #(
      .ADDR_BYTES(g + 1),
      .TIMEOUT   ((g == 0) ? TMO : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_rnw   (req_rnw[g]),
      .req_dev   (req_dev[g]),
      .req_reg   (req_reg[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_rnw   (rsp_rnw[g]),
      .rsp_nack  (rsp_nack[g]),
      .rsp_al    (rsp_al[g]),
      .rsp_tmo   (rsp_tmo[g]),
      .busy      (busy[g]),
      .bc_start  (bc_start[g]),
      .bc_stop   (bc_stop[g]),
      .bc_read   (bc_read[g]),
      .bc_write  (bc_write[g]),
      .bc_ack_in (bc_ack_in[g]),
      .bc_din    (bc_din[g]),
      .bc_cmd_ack(bc_cmd_ack[g]),
      .bc_ack_out(bc_ack_out[g]),
      .bc_dout   (bc_dout[g]),
      .bc_al     (bc_al[g]),
      .bc_rst    (bc_rst[g])
    );
  end

  cmd_t       exp_cmd_q[$];
  rsp_t       exp_rsp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         act = 0;
  int         stall_idx = -1;
  int         nack_idx = -1;
  int         al_idx = -1;
  logic [7:0] rd_byte = '0;
  int         cmd_idx = 0;
  bit         pending = 1'b0;
  int         wait_cyc = 0;
  int         n_bcrst = 0;
  cmd_t       held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic cmd_t obs_cmd(input int d);
    cmd_t c;
    c = {bc_start[d], bc_stop[d], bc_read[d], bc_write[d], bc_ack_in[d], bc_din[d]};
    return c;
  endfunction

  function automatic logic [31:0] out_vec(input int d);
    return {3'b000, req_ready[d], busy[d], rsp_valid[d], rsp_rdata[d], rsp_rnw[d],
            rsp_nack[d], rsp_al[d], rsp_tmo[d], bc_rst[d], obs_cmd(d)};
  endfunction

  function automatic cmd_t mk(input logic s, input logic p, input logic r, input logic w,
                              input logic a, input logic [7:0] din);
    cmd_t c;
    c = {s, p, r, w, a, din};
    return c;
  endfunction

  function automatic rsp_t mkr(input logic rnw, input logic nk, input logic al, input logic tmo,
                               input logic [7:0] rd);
    rsp_t r;
    r = {rnw, nk, al, tmo, rd};
    return r;
  endfunction

  // Byte-controller model plus command and response scoreboards, all sampled on negedge.
  initial begin
    cmd_t co, ce;
    rsp_t ro, re;
    bc_cmd_ack = '0;
    bc_ack_out = '0;
    bc_al      = '0;
    bc_dout    = '0;
    forever begin
      @(negedge clk);
      bc_cmd_ack = '0;
      bc_ack_out = '0;
      bc_al      = '0;
      bc_dout    = 16'($urandom);
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (exp_rsp_q.size() == 0) begin
            check("rsp_extra", 32'd1, 32'd0);
          end else begin
            re = exp_rsp_q.pop_front();
            ro = {rsp_rnw[d], rsp_nack[d], rsp_al[d], rsp_tmo[d], rsp_rdata[d]};
            check("rsp", ro, re);
          end
        end
      end
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) wait_cyc++;
        if (bc_rst[act]) begin
          n_bcrst++;
          check("tmo_cycles", wait_cyc, TMO);
          pending = 1'b0;
        end else if (pending) begin
          co = obs_cmd(act);
          check("cmd_hold", co, held);
          if ((cmd_idx != stall_idx) && (wait_cyc >= LAT)) begin
            bc_cmd_ack[act] = 1'b1;
            if (cmd_idx == al_idx) begin
              bc_al[act] = 1'b1;
            end else begin
              bc_ack_out[act] = (cmd_idx == nack_idx);
              bc_dout[act]    = rd_byte;
            end
            pending = 1'b0;
            cmd_idx++;
          end
        end else begin
          co = obs_cmd(act);
          if (co != '0) begin
            if (exp_cmd_q.size() == 0) begin
              check("cmd_extra", co, 32'd0);
            end else begin
              ce = exp_cmd_q.pop_front();
              if (!ce.wr) check("cmd_ctrl", co[12:8], ce[12:8]);
              else        check("cmd", co, ce);
            end
            held     = co;
            pending  = 1'b1;
            wait_cyc = 0;
          end
        end
      end
    end
  end

  task automatic cfg(input int d, input int st, input int nk, input int al, input logic [7:0] rb);
    act       = d;
    stall_idx = st;
    nack_idx  = nk;
    al_idx    = al;
    rd_byte   = rb;
    cmd_idx   = 0;
  endtask

  task automatic issue(input int d, input logic rnw, input logic [6:0] dev, input logic [15:0] rg,
                       input logic [7:0] wd, input int extra_hold);
    int t;
    t = 0;
    while (!req_ready[d] && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_req", req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_rnw[d]   = rnw;
    req_dev[d]   = dev;
    req_reg[d]   = rg;
    req_wdata[d] = wd;
    @(negedge clk);
    check("first_cmd_start_write", {bc_start[d], bc_write[d]}, 2'b11);
    check("flags_clear_on_accept", {rsp_nack[d], rsp_al[d], rsp_tmo[d], rsp_rdata[d]}, 0);
    for (int i = 0; i < extra_hold; i++) begin
      req_rnw[d] = ~rnw;
      req_dev[d] = ~dev;
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input rsp_t e);
    int t;
    t = 0;
    while (!rsp_valid[d] && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    check("rsp_seen", rsp_valid[d], 1);
    check("ready_low_in_done", req_ready[d], 0);
    check("cmd_idle_in_done", obs_cmd(d), 0);
    @(negedge clk);
    check("ready_after_done", {req_ready[d], busy[d], rsp_valid[d]}, 3'b100);
    check("flags_hold", {rsp_rnw[d], rsp_nack[d], rsp_al[d], rsp_tmo[d], rsp_rdata[d]}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rsp_t e;
    rst       = 1'b1;
    req_valid = '0;
    req_rnw   = '0;
    req_dev   = '0;
    req_reg   = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check("reset_state", out_vec(d), 32'h1000_0000);
    rst = 1'b0;
    @(negedge clk);

    // Write, 1-byte address, all ACK; upper register byte must be ignored.
    cfg(0, -1, -1, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h12));
    exp_cmd_q.push_back(mk(0, 1, 0, 1, 0, 8'hA5));
    e = mkr(0, 0, 0, 0, 8'h00);
    exp_rsp_q.push_back(e);
    issue(0, 1'b0, 7'h50, 16'hEE12, 8'hA5, 0);
    wait_done(0, e);

    // Read, 2-byte address, request held valid while busy.
    cfg(1, -1, -1, -1, 8'h3C);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hD0));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h12));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h34));
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hD1));
    exp_cmd_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
    e = mkr(1, 0, 0, 0, 8'h3C);
    exp_rsp_q.push_back(e);
    issue(1, 1'b1, 7'h68, 16'h1234, 8'h00, 2);
    wait_done(1, e);

    // NACK on device address: stop-only follows, no register byte.
    cfg(0, -1, 0, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    e = mkr(0, 1, 0, 0, 8'h00);
    exp_rsp_q.push_back(e);
    issue(0, 1'b0, 7'h50, 16'h0012, 8'hA5, 0);
    wait_done(0, e);

    // NACK on the data byte: no extra stop.
    cfg(1, -1, 3, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h54));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'hBE));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'hEF));
    exp_cmd_q.push_back(mk(0, 1, 0, 1, 0, 8'h5A));
    e = mkr(0, 1, 0, 0, 8'h00);
    exp_rsp_q.push_back(e);
    issue(1, 1'b0, 7'h2A, 16'hBEEF, 8'h5A, 0);
    wait_done(1, e);

    // Arbitration lost during REG_LO, coincident with cmd_ack.
    cfg(1, -1, -1, 2, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h22));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h03));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h04));
    e = mkr(0, 0, 1, 0, 8'h00);
    exp_rsp_q.push_back(e);
    issue(1, 1'b0, 7'h11, 16'h0304, 8'h77, 0);
    wait_done(1, e);

    // Timeout: ack withheld on the first command.
    cfg(0, 0, -1, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hFE));
    e = mkr(0, 0, 0, 1, 8'h00);
    exp_rsp_q.push_back(e);
    issue(0, 1'b0, 7'h7F, 16'h0001, 8'h02, 0);
    wait_done(0, e);
    check("bc_rst_after_tmo", n_bcrst, 1);

    // Read, 1-byte address.
    cfg(0, -1, -1, -1, 8'hC3);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h74));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h5C));
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h75));
    exp_cmd_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
    e = mkr(1, 0, 0, 0, 8'hC3);
    exp_rsp_q.push_back(e);
    issue(0, 1'b1, 7'h3A, 16'h005C, 8'h00, 0);
    wait_done(0, e);

    // Reset while DEV_R is outstanding.
    cfg(0, 2, -1, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h42));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h0A));
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h43));
    issue(0, 1'b1, 7'h21, 16'h000A, 8'h00, 0);
    t = 0;
    while (!((cmd_idx == 2) && pending) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("dev_r_reached", (cmd_idx == 2) && pending, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_txn", out_vec(0), 32'h1000_0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", out_vec(0), 32'h1000_0000);

    // Recovery write after the mid-transaction reset.
    cfg(0, -1, -1, -1, 8'h00);
    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'h0A));
    exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h80));
    exp_cmd_q.push_back(mk(0, 1, 0, 1, 0, 8'h00));
    e = mkr(0, 0, 0, 0, 8'h00);
    exp_rsp_q.push_back(e);
    issue(0, 1'b0, 7'h05, 16'h0080, 8'h00, 0);
    wait_done(0, e);

    repeat (3) @(negedge clk);
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("rsp_q_drained", exp_rsp_q.size(), 0);
    check("bc_rst_total", n_bcrst, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_reg_seq.md
# i2c_master_reg_seq

Register-transaction sequencer sitting directly upstream of the I2C master byte controller. It accepts a single-register read or write request (7-bit device address, register address, one data byte). It expands the request into the byte-level start/write/read/stop command sequence, and holds each command until the byte controller's `cmd_ack`. It reports one response per request: read data, NACK, arbitration-lost or timeout.

## Interface
Parameters:
- `ADDR_BYTES`, 1: register-address bytes sent, MSB first. Only 1 or 2 are legal; any other value is an elaboration error.
- `TIMEOUT`, 65535: maximum clk cycles to wait for `cmd_ack` on any one command. 0 disables the timeout.

Ports:
- `clk` in 1: master clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_dev` in 7: 7-bit device address.
- `req_reg` in 16: register address. Only `[7:0]` is used when `ADDR_BYTES`=1.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 8: read data, valid with `rsp_valid` when `rsp_rnw`=1.
- `rsp_rnw` out 1: echo of `req_rnw`.
- `rsp_nack` / `rsp_al` / `rsp_tmo` out 1 each: error flags, valid with `rsp_valid`.
- `busy` out 1: state is not IDLE.
- `bc_start` / `bc_stop` / `bc_read` / `bc_write` / `bc_ack_in` out 1 each: byte-controller command bits.
- `bc_din` out 8: byte to transmit.
- `bc_cmd_ack` in 1: byte controller `cmd_ack`.
- `bc_ack_out` in 1: received ACK bit, 0 = ACK.
- `bc_dout` in 8: received byte.
- `bc_al` in 1: arbitration lost.
- `bc_rst` out 1: one-cycle pulse to byte-controller `rst`, issued on timeout.

## Operation
- **Accept.** A request is accepted when `req_valid & req_ready`. All `req_*` fields are latched at that point.
- **Write sequence:**
  - DEV_W: `start+write`, `din={dev,0}`
  - REG_HI: `write`, `din=reg[15:8]`; skipped when `ADDR_BYTES`=1
  - REG_LO: `write`, `din=reg[7:0]`
  - WDATA: `write+stop`, `din=wdata`
  - DONE
- **Read sequence:**
  - DEV_W, then REG_HI/REG_LO, as for a write
  - DEV_R: `start+write` (repeated start), `din={dev,1}`
  - RDATA: `read+stop`, `ack_in=1` (master NACK)
  - DONE
- **Command hold.** Each state drives its command bits constantly until `bc_cmd_ack`=1. On that edge the next state's command bits are loaded. The bits are therefore low or changed in the cycle after the ack, and the byte controller never sees a stale `go`.
- **NACK.** `bc_ack_out` is sampled on the `cmd_ack` cycle.
  - NACK on DEV_W, REG_HI, REG_LO or DEV_R: set `rsp_nack`, go to STOP (`stop` only), then DONE on its ack.
  - NACK on WDATA: set `rsp_nack`, go straight to DONE, because the stop was already issued.
- **Read capture.** In RDATA, `bc_dout` is captured into `rsp_rdata` on the `cmd_ack` cycle.
- **Arbitration lost.** `bc_al`=1 in any state other than IDLE or DONE: all command bits are cleared, `rsp_al` is set, and the state goes to DONE. No stop is issued, because the byte controller self-resets.
- **Timeout.** The wait counter clears whenever a command is loaded and increments while waiting. When it reaches `TIMEOUT`:
  - all command bits are cleared;
  - `bc_rst` pulses for one cycle;
  - `rsp_tmo` is set;
  - the state goes to DONE.
- **DONE.** `rsp_valid` pulses for one cycle and the state returns to IDLE. Error flags and `rsp_rdata` hold their values until the next request is accepted, then clear.

## Timing
- **Reset values.** All outputs are 0, except `req_ready`=1. State is IDLE. The counter is 0.
- **Latency.**
  - The first command is asserted the cycle after acceptance.
  - `rsp_valid` is asserted the cycle after the final `cmd_ack`, AL or timeout.
  - `req_ready` returns the cycle after `rsp_valid`, so the minimum request-to-request gap is 2 cycles plus the bus time.
- **Simultaneous events:**
  - `bc_al` and `bc_cmd_ack` in the same cycle: AL wins.
  - `cmd_ack` and counter==`TIMEOUT` in the same cycle: `cmd_ack` wins.
  - `req_valid` is ignored while busy.
- **Reset mid-transaction.** `rst` causes an immediate return to IDLE. No `rsp_valid` and no `bc_rst` pulse are issued, and command bits are 0 on the next cycle.
- **Counter.** Width is `$clog2(TIMEOUT+1)`. It never wraps: it saturates at the limit and the abort is taken.

## Structure
- **Package `i2c_seq_pkg`:**
  - state enum: IDLE, DEV_W, REG_HI, REG_LO, DEV_R, WDATA, RDATA, STOP, DONE;
  - constants `I2C_WR_BIT=1'b0` and `I2C_RD_BIT=1'b1`;
  - a function that builds the address byte `{dev,rw}`.
- **Sub-module `i2c_seq_timeout`:** clear/enable saturating counter with a `hit` output.
- **Top level:** FSM and response registers.

## Test plan
- **Write, all ACK.** Write dev=0x50, reg=0x12, wdata=0xA5, `ADDR_BYTES`=1 → `bc_din` sequence A0, 12, A5; stop asserted with A5; `rsp_valid` with all flags 0.
- **Read, 2-byte address.** Read dev=0x68, reg=0x1234, `ADDR_BYTES`=2, byte model returns 0x3C → `din` sequence D0, 12, 34, D1; repeated start on D1; `ack_in`=1 on the read; `rsp_rdata`=0x3C.
- **NACK on device address.** `bc_ack_out`=1 on the DEV_W ack → stop-only command; `rsp_nack`=1; no REG byte sent.
- **Arbitration lost.** `bc_al` pulsed during REG_LO → commands 0 next cycle; `rsp_al`=1; no stop; `req_ready`=1 two cycles later.
- **Timeout.** `TIMEOUT`=20, `cmd_ack` withheld → `bc_rst` pulse exactly 20 cycles after the command is loaded; `rsp_tmo`=1.
- **Reset mid-transaction.** `rst` during DEV_R → IDLE next cycle, all outputs at reset values, no `rsp_valid`.
